// File: rtl/ram1_byte_loader.sv
// ============================================================================
// Module   : ram1_byte_loader
// Purpose  : Packs received bytes into little-endian words, writes them to
//            Ram1 with the EN/OE/WE strobe sequence and reads each one back.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram1_byte_loader #(
    parameter logic [17:0] BASE_ADDR = 18'd0,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned WE_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    input  logic        flush,
    output logic        Ram1_EN,
    output logic        Ram1_OE,
    output logic        Ram1_WE,
    output logic [17:0] Ram1_address,
    inout  wire  [15:0] Ram1_data,
    output logic [17:0] word_count,
    output logic        full,
    output logic        verify_err,
    output logic [17:0] err_addr
);

    localparam int c_CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_STROBE_LAST = c_CNT_W'(WE_CYCLES - 1);
    // One extra bit so a DEPTH of 2^18 is still reachable.
    localparam logic [18:0] c_DEPTH = 19'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOW_HELD = 3'd1,
        S_SETUP    = 3'd2,
        S_STROBE   = 3'd3,
        S_HOLD     = 3'd4,
        S_TURN     = 3'd5,
        S_VERIFY   = 3'd6
    } state_t;

    state_t              r_state;
    logic [7:0]          r_low;
    logic [15:0]         r_word;
    logic                r_drive;
    logic                r_en;
    logic                r_oe;
    logic                r_we;
    logic [17:0]         r_addr;
    logic [18:0]         r_count;
    logic                r_full;
    logic                r_err;
    logic [17:0]         r_err_addr;
    logic [c_CNT_W-1:0]  r_we_cnt;

    logic                w_xfer;
    logic                w_start;
    logic [15:0]         w_next_word;
    logic [18:0]         w_count_inc;

    assign in_ready    = ((r_state == S_IDLE) || (r_state == S_LOW_HELD)) && !r_full;
    assign w_xfer      = in_valid && in_ready;
    // A byte arriving in the same cycle as flush completes the word instead.
    assign w_start     = (r_state == S_LOW_HELD) && (w_xfer || (flush && !r_full));
    assign w_next_word = w_xfer ? {in_byte, r_low} : {8'h00, r_low};
    assign w_count_inc = r_count + 19'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_low      <= 8'h00;
            r_word     <= 16'h0000;
            r_drive    <= 1'b0;
            r_en       <= 1'b1;
            r_oe       <= 1'b1;
            r_we       <= 1'b1;
            r_addr     <= BASE_ADDR;
            r_count    <= 19'd0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= 18'd0;
            r_we_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_low   <= in_byte;
                        r_state <= S_LOW_HELD;
                    end
                end
                S_LOW_HELD: begin
                    if (w_start) begin
                        r_word  <= w_next_word;
                        r_drive <= 1'b1;
                        r_en    <= 1'b0;
                        r_addr  <= BASE_ADDR + r_count[17:0];
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_we     <= 1'b0;
                    r_we_cnt <= c_STROBE_LAST;
                    r_state  <= S_STROBE;
                end
                S_STROBE: begin
                    if (r_we_cnt == '0) begin
                        r_we    <= 1'b1;
                        r_state <= S_HOLD;
                    end else begin
                        r_we_cnt <= r_we_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    // Release the bus on the same edge the SRAM gets OE.
                    r_drive <= 1'b0;
                    r_oe    <= 1'b0;
                    r_state <= S_TURN;
                end
                S_TURN: begin
                    r_state <= S_VERIFY;
                end
                S_VERIFY: begin
                    if (Ram1_data != r_word) begin
                        r_err <= 1'b1;
                        if (!r_err) begin
                            r_err_addr <= r_addr;
                        end
                    end
                    r_en    <= 1'b1;
                    r_oe    <= 1'b1;
                    r_count <= w_count_inc;
                    if (w_count_inc == c_DEPTH) begin
                        r_full <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Ram1_data    = r_drive ? r_word : 16'hzzzz;
    assign Ram1_EN      = r_en;
    assign Ram1_OE      = r_oe;
    assign Ram1_WE      = r_we;
    assign Ram1_address = r_addr;
    assign word_count   = r_count[17:0];
    assign full         = r_full;
    assign verify_err   = r_err;
    assign err_addr     = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_ram1_byte_loader.sv
// ============================================================================
// Module   : tb_ram1_byte_loader
// Purpose  : Directed bench for ram1_byte_loader with a small Ram1 model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram1_byte_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, rstB, valA, valB, flA, flB;
    logic [7:0]  byA, byB;
    logic        rdyA, rdyB, enA, oeA, weA, enB, oeB, weB;
    logic        fullA, fullB, errA, errB;
    logic [17:0] addrA, addrB, wcA, wcB, eaA, eaB;
    wire  [15:0] busA, busB;

    logic [15:0] memA [16];
    logic [15:0] memB [16];
    logic        faultA = 1'b0;
    logic        weA_prev = 1'b1, weB_prev = 1'b1;
    int          writesA = 0, writesB = 0, weLowA = 0, enLowA = 0, viol = 0;
    logic [17:0] last_waddrA = '0, maxaddrB = '0;
    int          n_tests = 0, n_fail = 0;

    ram1_byte_loader #(.BASE_ADDR(18'd0), .DEPTH(1024), .WE_CYCLES(2)) u_dut_a (
        .CLK(clk), .RST(rstA), .in_valid(valA), .in_byte(byA), .in_ready(rdyA),
        .flush(flA), .Ram1_EN(enA), .Ram1_OE(oeA), .Ram1_WE(weA),
        .Ram1_address(addrA), .Ram1_data(busA), .word_count(wcA), .full(fullA),
        .verify_err(errA), .err_addr(eaA)
    );

    ram1_byte_loader #(.BASE_ADDR(18'd0), .DEPTH(4), .WE_CYCLES(1)) u_dut_b (
        .CLK(clk), .RST(rstB), .in_valid(valB), .in_byte(byB), .in_ready(rdyB),
        .flush(flB), .Ram1_EN(enB), .Ram1_OE(oeB), .Ram1_WE(weB),
        .Ram1_address(addrB), .Ram1_data(busB), .word_count(wcB), .full(fullB),
        .verify_err(errB), .err_addr(eaB)
    );

    // SRAM models; instance A can corrupt bit 0 on readback of words 3 and 5.
    assign busA = (!enA && !oeA)
                ? (memA[addrA[3:0]] ^ {15'd0, faultA && (addrA == 18'd3 || addrA == 18'd5)})
                : 16'hzzzz;
    assign busB = (!enB && !oeB) ? memB[addrB[3:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!enA && !weA) memA[addrA[3:0]] <= busA;
        if (!enB && !weB) memB[addrB[3:0]] <= busB;
        if (!weA && weA_prev) begin
            writesA     <= writesA + 1;
            last_waddrA <= addrA;
        end
        if (!weB && weB_prev) begin
            writesB <= writesB + 1;
            if (addrB > maxaddrB) maxaddrB <= addrB;
        end
        weA_prev <= weA;
        weB_prev <= weB;
    end

    always @(negedge clk) begin
        if (!weA) weLowA <= weLowA + 1;
        if (!enA) enLowA <= enLowA + 1;
        if ((!oeA && !weA) || (!oeB && !weB) ||
            (!enA && !oeA && $isunknown(busA)) || (!enB && !oeB && $isunknown(busB)))
            viol <= viol + 1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? rdyA : rdyB;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] b, input logic f);
        if (sel == 0) begin valA = v; byA = b; flA = f; end
        else          begin valB = v; byB = b; flB = f; end
    endtask

    // Called at a negedge; returns at a negedge with inputs idle.
    task automatic send(input int sel, input logic [7:0] b, input logic f, output bit acc);
        acc = 1'b0;
        drive(sel, 1'b1, b, f);
        for (int i = 0; i < 20 && !acc; i++) begin
            if (rdy(sel)) acc = 1'b1;
            @(negedge clk);
        end
        drive(sel, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        while (!rdy(sel) && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk_eq("idle_wait", {31'd0, rdy(sel)}, 32'd1);
    endtask

    task automatic pair(input int sel, input logic [7:0] lo, input logic [7:0] hi);
        bit acc;
        send(sel, lo, 1'b0, acc);
        send(sel, hi, 1'b0, acc);
        wait_idle(sel);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n, base_we, base_en, base_wr, acc_cnt;
        rstA = 1'b1; rstB = 1'b1;
        valA = 1'b0; valB = 1'b0; flA = 1'b0; flB = 1'b0; byA = 8'h00; byB = 8'h00;
        repeat (2) @(negedge clk);

        chk_eq("rst_en",    {31'd0, enA}, 32'd1);
        chk_eq("rst_oe",    {31'd0, oeA}, 32'd1);
        chk_eq("rst_we",    {31'd0, weA}, 32'd1);
        chk_eq("rst_busz",  {31'd0, busA === 16'hzzzz}, 32'd1);
        chk_eq("rst_addr",  {14'd0, addrA}, 32'd0);
        chk_eq("rst_wc",    {14'd0, wcA}, 32'd0);
        chk_eq("rst_flags", {29'd0, fullA, errA, rdyA}, 32'd1);
        chk_eq("rst_eaddr", {14'd0, eaA}, 32'd0);
        rstA = 1'b0; rstB = 1'b0;
        @(negedge clk);

        // Back-to-back pair
        base_we = weLowA;
        send(0, 8'h34, 1'b0, acc);
        send(0, 8'h12, 1'b0, acc);
        n = 0;
        while (!rdyA && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk_eq("t1_busy_cycles", n, 32'd6);
        chk_eq("t1_we_low", weLowA - base_we, 32'd2);
        chk_eq("t1_mem0", {16'd0, memA[0]}, 32'h1234);
        chk_eq("t1_wc", {14'd0, wcA}, 32'd1);
        chk_eq("t1_busz", {31'd0, busA === 16'hzzzz}, 32'd1);
        chk_eq("t1_addr_hold", {14'd0, addrA}, 32'd0);

        // Flush of a lone low byte, then flush with nothing pending
        send(0, 8'hAB, 1'b0, acc);
        flA = 1'b1; @(negedge clk); flA = 1'b0;
        wait_idle(0);
        chk_eq("t2_mem1", {16'd0, memA[1]}, 32'h00AB);
        chk_eq("t2_wc", {14'd0, wcA}, 32'd2);
        base_en = enLowA;
        base_wr = writesA;
        flA = 1'b1; @(negedge clk); flA = 1'b0;
        repeat (4) @(negedge clk);
        chk_eq("t2_idle_flush_en", enLowA - base_en, 32'd0);
        chk_eq("t2_idle_flush_wc", {14'd0, wcA}, 32'd2);

        // Byte and flush together
        send(0, 8'h11, 1'b0, acc);
        send(0, 8'h22, 1'b1, acc);
        wait_idle(0);
        chk_eq("t3_mem2", {16'd0, memA[2]}, 32'h2211);
        chk_eq("t3_writes", writesA - base_wr, 32'd1);
        chk_eq("t3_wc", {14'd0, wcA}, 32'd3);

        // Readback faults at addresses 3 and 5
        faultA = 1'b1;
        chk_eq("t4_err_before", {31'd0, errA}, 32'd0);
        pair(0, 8'h55, 8'h66);
        chk_eq("t4_err_set", {31'd0, errA}, 32'd1);
        chk_eq("t4_eaddr3", {14'd0, eaA}, 32'd3);
        pair(0, 8'h77, 8'h88);
        pair(0, 8'h99, 8'hAA);
        chk_eq("t4_eaddr_kept", {14'd0, eaA}, 32'd3);
        chk_eq("t4_wc", {14'd0, wcA}, 32'd6);
        chk_eq("t4_mem4", {16'd0, memA[4]}, 32'h8877);
        chk_eq("t4_mem5", {16'd0, memA[5]}, 32'hAA99);
        faultA = 1'b0;

        // Reset in the middle of the write strobe
        send(0, 8'hC3, 1'b0, acc);
        send(0, 8'h3C, 1'b0, acc);
        n = 0;
        while (weA && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk_eq("t5_in_strobe", {31'd0, weA}, 32'd0);
        #2 rstA = 1'b1;
        #1;
        chk_eq("t5_strobes", {29'd0, enA, oeA, weA}, 32'd7);
        chk_eq("t5_busz", {31'd0, busA === 16'hzzzz}, 32'd1);
        chk_eq("t5_wc", {14'd0, wcA}, 32'd0);
        chk_eq("t5_err_clr", {31'd0, errA}, 32'd0);
        @(negedge clk);
        rstA = 1'b0;
        @(negedge clk);
        pair(0, 8'h0F, 8'hF0);
        chk_eq("t5_mem0", {16'd0, memA[0]}, 32'hF00F);
        chk_eq("t5_waddr", {14'd0, last_waddrA}, 32'd0);
        chk_eq("t5_wc_after", {14'd0, wcA}, 32'd1);

        // DEPTH=4 instance: ten bytes, only eight fit
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            send(1, 8'(i + 1), 1'b0, acc);
            if (acc) acc_cnt++;
            if (i == 5) begin
                wait_idle(1);
                chk_eq("t6_not_full_3", {31'd0, fullB}, 32'd0);
                chk_eq("t6_wc3", {14'd0, wcB}, 32'd3);
            end
        end
        repeat (8) @(negedge clk);
        chk_eq("t6_accepted", acc_cnt, 32'd8);
        chk_eq("t6_full", {31'd0, fullB}, 32'd1);
        chk_eq("t6_ready", {31'd0, rdyB}, 32'd0);
        chk_eq("t6_wc", {14'd0, wcB}, 32'd4);
        chk_eq("t6_writes", writesB, 32'd4);
        chk_eq("t6_maxaddr", {14'd0, maxaddrB}, 32'd3);
        chk_eq("t6_mem0", {16'd0, memB[0]}, 32'h0201);
        chk_eq("t6_mem3", {16'd0, memB[3]}, 32'h0807);
        chk_eq("t6_err", {31'd0, errB}, 32'd0);

        chk_eq("bus_protocol", viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram1_byte_loader.md
Name: ram1_byte_loader

Overview:
- Downstream stage of the UART byte-read controller. Accepts received bytes over a valid/ready handshake.
- Packs each pair of bytes into one little-endian 16-bit word and writes it to Ram1 at consecutive addresses, using the EN/OE/WE strobe protocol.
- Reads every word back and flags a mismatch. It is the bulk-load path that fills Ram1 from the serial port.

Parameters:
- BASE_ADDR, 18'd0, Ram1 address of the first word written.
- DEPTH, 1024, number of words the block may write before it reports full (1..2^18).
- WE_CYCLES, 1, number of cycles Ram1_WE is held low per write (>=1).

Ports:
- CLK  input  1  system clock, 11 MHz.
- RST  input  1  asynchronous reset, active-high.
- in_valid  input  1  upstream has a received byte on in_byte.
- in_byte  input  8  received byte.
- in_ready  output  1  block can accept a byte this cycle.
- flush  input  1  write a pending low byte as a partial word, with the high byte 8'h00.
- Ram1_EN  output  1  SRAM chip enable, active-low.
- Ram1_OE  output  1  SRAM output enable, active-low.
- Ram1_WE  output  1  SRAM write enable, active-low.
- Ram1_address  output  18  SRAM word address.
- Ram1_data  inout  16  SRAM data bus; high-Z when the block is not driving it.
- word_count  output  18  number of words written since reset.
- full  output  1  word_count == DEPTH.
- verify_err  output  1  sticky; a readback mismatch has occurred.
- err_addr  output  18  address of the first mismatch.

Behaviour:
- Reset (asynchronous, takes effect immediately, including in the middle of a write):
  - Ram1_EN, Ram1_OE and Ram1_WE are 1.
  - Ram1_data is high-Z. Ram1_address = BASE_ADDR.
  - word_count = 0, full = 0, verify_err = 0, err_addr = 0.
  - in_ready = 1, state = IDLE, pending byte cleared.
- A byte is transferred on a rising CLK edge when in_valid and in_ready are both 1.
- in_ready = 1 only in IDLE and LOW_HELD, and only while full = 0.
- IDLE:
  - On transfer, the low byte is latched and the state goes to LOW_HELD.
  - flush has no effect in IDLE.
- LOW_HELD:
  - On transfer, word = {in_byte, low} and the state goes to SETUP.
  - Otherwise, if flush = 1, word = {8'h00, low} and the state goes to SETUP.
  - When transfer and flush occur in the same cycle, the transfer wins and flush is ignored.
- SETUP (1 cycle):
  - Ram1_EN = 0, Ram1_OE = 1, Ram1_WE = 1.
  - Ram1_data driven with word. Ram1_address = BASE_ADDR + word_count.
- STROBE (WE_CYCLES cycles):
  - Ram1_WE = 0. Data and address stay stable.
- HOLD (1 cycle):
  - Ram1_WE = 1. Data is still driven, which gives hold time.
- TURN (1 cycle):
  - Ram1_data is released to high-Z. Ram1_OE = 0.
- VERIFY (1 cycle):
  - Ram1_OE = 0. Ram1_data is sampled at the end of the cycle and compared with word.
  - On mismatch: verify_err is set. err_addr is captured only if verify_err was previously 0.
  - Then Ram1_EN = 1, Ram1_OE = 1, word_count is incremented, and the state returns to IDLE.
- Timing:
  - Write latency from the accepting edge of the second byte back to IDLE is 4 + WE_CYCLES cycles.
  - in_ready = 0 throughout SETUP..VERIFY.
- Bus ownership:
  - The block drives Ram1_data only in SETUP, STROBE and HOLD.
  - Ram1_OE is never 0 while the block drives the bus.
  - Ram1_WE is never 0 while Ram1_OE = 0.
- Ram1_address holds its last value outside a write.
- full:
  - Set when word_count reaches DEPTH.
  - While full, in_ready = 0 and flush is ignored.
  - A held low byte in LOW_HELD is retained, but it cannot become full first, since full only follows a completed word.
  - full clears only on reset.
- word_count saturates at DEPTH. The address never wraps past BASE_ADDR + DEPTH - 1.

Test Plan:
- Reset, then send bytes 0x34, 0x12 back-to-back → one write to address BASE_ADDR of 16'h1234.
  - WE low exactly WE_CYCLES cycles; word_count = 1.
  - in_ready low for 4 + WE_CYCLES cycles after the second byte.
- Send 0xAB, then pulse flush → write of 16'h00AB.
  - Flush pulsed in IDLE with no pending byte → no Ram1 activity.
- Byte and flush asserted in the same cycle in LOW_HELD (low = 0x11, byte = 0x22) → word 16'h2211; flush ignored.
- SRAM model forces bit 0 on address 3 → verify_err = 1 and err_addr = 3.
  - A later mismatch at address 5 leaves err_addr = 3.
  - Writes continue regardless.
- DEPTH = 4, send 10 bytes → words at addresses 0..3 only; full = 1 after the 4th write.
  - in_ready stays 0; bytes 9–10 are not accepted.
- Assert RST during STROBE → same cycle:
  - WE/OE/EN = 1 and Ram1_data = Z.
  - word_count = 0; the next write goes to BASE_ADDR.
